// File: rtl/mp_limb_serial_addsub_if.sv
// rtl/mp_limb_serial_addsub_if.sv - limb stream in/out bundle for mp_limb_serial_addsub
// oG/oP exist only when CLA_GP_OUT_EN is defined.
interface mp_limb_serial_addsub_if #(
  parameter int LIMB_WIDTH = 12
);
  logic                  iValid;
  logic                  oReady;
  logic [LIMB_WIDTH-1:0] iA;
  logic [LIMB_WIDTH-1:0] iB;
  logic                  iSub;
  logic                  iFirst;
  logic                  iLast;
  logic                  oValid;
  logic                  iReady;
  logic [LIMB_WIDTH-1:0] oSum;
  logic                  oLast;
  logic                  oC;
  logic                  oErr;
`ifdef CLA_GP_OUT_EN
  logic                  oG;
  logic                  oP;
`endif

  modport slave (
    input  iValid, iA, iB, iSub, iFirst, iLast, iReady,
    output oReady, oValid, oSum, oLast, oC, oErr
`ifdef CLA_GP_OUT_EN
    , output oG, oP
`endif
  );

  modport master (
    output iValid, iA, iB, iSub, iFirst, iLast, iReady,
    input  oReady, oValid, oSum, oLast, oC, oErr
`ifdef CLA_GP_OUT_EN
    , input oG, oP
`endif
  );
endinterface

// File: rtl/mp_limb_serial_addsub.sv
// rtl/mp_limb_serial_addsub.sv - limb-serial multi-precision adder/subtractor
// Optional macro CLA_GP_OUT_EN registers per-limb group generate/propagate onto oG/oP.
module mp_limb_serial_addsub #(
  parameter int LIMB_WIDTH = 12,
  parameter int MAX_LIMBS  = 16
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  mp_limb_serial_addsub_if.slave       bus
);
  localparam int CW = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic                  carry_q, carry_d;
  logic                  sub_q, sub_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [LIMB_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                  out_last_q, out_last_d;
  logic                  out_c_q, out_c_d;
  logic                  out_err_q, out_err_d;
  logic                  out_g_q, out_g_d;
  logic                  out_p_q, out_p_d;

  logic                  ready;
  logic                  accept;
  logic                  sub_eff;
  logic [LIMB_WIDTH-1:0] bop;
  logic                  cin;
  logic [LIMB_WIDTH:0]   gp_sum;
  logic                  grp_g;
  logic                  grp_p;
  logic                  cout;
  logic [LIMB_WIDTH-1:0] sum;
  logic                  at_limit;
  logic                  emit;
  logic                  emit_last;

  // Limb datapath: carry-out comes from group G/P plus the incoming carry.
  always_comb begin
    ready    = !out_valid_q || bus.iReady;
    accept   = bus.iValid && ready;
    sub_eff  = bus.iFirst ? bus.iSub : sub_q;
    bop      = sub_eff ? ~bus.iB : bus.iB;
    cin      = bus.iFirst ? bus.iSub : carry_q;
    gp_sum   = {1'b0, bus.iA} + {1'b0, bop};
    grp_g    = gp_sum[LIMB_WIDTH];
    grp_p    = &(bus.iA ^ bop);
    cout     = grp_g | (grp_p & cin);
    sum      = gp_sum[LIMB_WIDTH-1:0] + {{(LIMB_WIDTH-1){1'b0}}, cin};
    at_limit = (count_q == CW'(MAX_LIMBS - 1));
  end

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    count_d     = count_q;
    out_valid_d = out_valid_q && !bus.iReady;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_c_d     = out_c_q;
    out_err_d   = 1'b0;
    out_g_d     = out_g_q;
    out_p_d     = out_p_q;
    emit        = 1'b0;
    emit_last   = 1'b0;

    if (accept) begin
      if (bus.iFirst) begin
        // A first beat mid-operation abandons the old one and restarts here.
        out_err_d = (state_q == S_RUN);
        emit      = 1'b1;
        sub_d     = bus.iSub;
        carry_d   = cout;
        if (bus.iLast) begin
          emit_last = 1'b1;
          state_d   = S_IDLE;
          count_d   = '0;
        end else begin
          state_d   = S_RUN;
          count_d   = CW'(1);
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            out_err_d = 1'b1;
          end
          S_RUN: begin
            emit    = 1'b1;
            carry_d = cout;
            count_d = count_q + CW'(1);
            if (bus.iLast) begin
              emit_last = 1'b1;
              state_d   = S_IDLE;
              count_d   = '0;
            end else if (at_limit) begin
              emit_last = 1'b1;
              out_err_d = 1'b1;
              state_d   = S_IDLE;
              count_d   = '0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum;
      out_last_d  = emit_last;
      out_c_d     = cout;
      out_g_d     = grp_g;
      out_p_d     = grp_p;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= S_IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_c_q     <= 1'b0;
      out_err_q   <= 1'b0;
      out_g_q     <= 1'b0;
      out_p_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_c_q     <= out_c_d;
      out_err_q   <= out_err_d;
      out_g_q     <= out_g_d;
      out_p_q     <= out_p_d;
    end
  end

  assign bus.oReady = ready;
  assign bus.oValid = out_valid_q;
  assign bus.oSum   = out_sum_q;
  assign bus.oLast  = out_last_q;
  assign bus.oC     = out_c_q;
  assign bus.oErr   = out_err_q;
`ifdef CLA_GP_OUT_EN
  assign bus.oG     = out_g_q;
  assign bus.oP     = out_p_q;
`else
  logic unused_gp;
  assign unused_gp = out_g_q ^ out_p_q;
`endif
endmodule

// File: tb/tb_mp_limb_serial_addsub.sv
// tb/tb_mp_limb_serial_addsub.sv - scoreboard bench for mp_limb_serial_addsub
module tb_mp_limb_serial_addsub;
  localparam int W    = 12;
  localparam int MAXL = 4;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  mp_limb_serial_addsub_if #(.LIMB_WIDTH(W)) bus();

  mp_limb_serial_addsub #(.LIMB_WIDTH(W), .MAX_LIMBS(MAXL)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] sum;
    logic         last;
    logic         c;
  } exp_t;

  exp_t exp_q[$];

  // Reference: whole-operand arithmetic over the limbs seen so far.
  bit              in_op;
  bit              m_sub;
  int              m_k;
  longint unsigned m_a;
  longint unsigned m_b;
  bit              prev_err;
  bit              hold_v;
  logic [W-1:0]    hold_sum;
  logic            hold_last;

  function automatic exp_t ref_limb(input int k, input bit last);
    exp_t            e;
    longint unsigned mask;
    longint unsigned res;
    mask = (64'd1 << (W * (k + 1))) - 64'd1;
    if (m_sub) begin
      res  = (m_a - m_b) & mask;
      e.c  = (m_a >= m_b);
    end else begin
      res  = m_a + m_b;
      e.c  = ((res >> (W * (k + 1))) & 64'd1) != 0;
    end
    e.sum  = W'(res >> (W * k));
    e.last = last;
    return e;
  endfunction

  always @(negedge iClk) begin
    exp_t e;
    bit   e_err;
    bit   lst;
    if (!iRst_n) begin
      exp_q.delete();
      in_op    = 0;
      prev_err = 0;
      hold_v   = 0;
    end else begin
      check("oErr", bus.oErr, prev_err);
      if (hold_v) begin
        check("hold_valid", bus.oValid, 1);
        check("hold_sum", bus.oSum, hold_sum);
        check("hold_last", bus.oLast, hold_last);
      end
      if (bus.oValid && !bus.iReady) check("stall_oReady", bus.oReady, 0);
      if (bus.oValid && bus.iReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("oSum", bus.oSum, e.sum);
          check("oLast", bus.oLast, e.last);
          if (e.last) check("oC", bus.oC, e.c);
        end
      end
      hold_v    = bus.oValid && !bus.iReady;
      hold_sum  = bus.oSum;
      hold_last = bus.oLast;

      e_err = 0;
      if (bus.iValid && bus.oReady) begin
        if (bus.iFirst) begin
          e_err = in_op;
          m_k   = 0;
          m_a   = longint'(bus.iA);
          m_b   = longint'(bus.iB);
          m_sub = bus.iSub;
          exp_q.push_back(ref_limb(0, bus.iLast));
          in_op = !bus.iLast;
        end else if (!in_op) begin
          e_err = 1;
        end else begin
          m_k++;
          m_a = m_a | (longint'(bus.iA) << (W * m_k));
          m_b = m_b | (longint'(bus.iB) << (W * m_k));
          lst = bus.iLast || (m_k == MAXL - 1);
          if (!bus.iLast && m_k == MAXL - 1) e_err = 1;
          exp_q.push_back(ref_limb(m_k, lst));
          in_op = !lst;
        end
      end
      prev_err = e_err;
    end
  end

  int rdy_mode = 0;
  initial begin
    bus.iReady = 1'b1;
    forever begin
      @(posedge iClk);
      #1;
      case (rdy_mode)
        0:       bus.iReady = 1'b1;
        1:       bus.iReady = ($urandom_range(0, 3) != 0);
        default: bus.iReady = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic f, input logic l);
    int n = 0;
    bus.iA     = a;
    bus.iB     = b;
    bus.iSub   = s;
    bus.iFirst = f;
    bus.iLast  = l;
    bus.iValid = 1'b1;
    @(negedge iClk);
    while (!bus.oReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (!bus.oReady) check("accept_timeout", 0, 1);
    @(posedge iClk);
    #1;
    bus.iValid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(posedge iClk);
    #0;
  endtask

  task automatic rand_op(input int n, input bit with_last);
    logic s;
    s = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      send(W'($urandom), W'($urandom), (i == 0) ? s : 1'($urandom_range(0, 1)),
           (i == 0), with_last && (i == n - 1));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge iClk);
        #1;
      end
    end
  endtask

  initial begin
    int n;
    bus.iValid = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iSub   = 1'b0;
    bus.iFirst = 1'b0;
    bus.iLast  = 1'b0;
    repeat (2) @(negedge iClk);
    check("rst_oValid", bus.oValid, 0);
    check("rst_oSum", bus.oSum, 0);
    check("rst_oLast", bus.oLast, 0);
    check("rst_oC", bus.oC, 0);
    check("rst_oErr", bus.oErr, 0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;

    send(12'hFFF, 12'h001, 1'b0, 1'b1, 1'b1);
    send(12'hFFF, 12'h001, 1'b0, 1'b1, 1'b0);
    send(12'hFFF, 12'h000, 1'b0, 1'b0, 1'b0);
    send(12'h000, 12'h000, 1'b0, 1'b0, 1'b1);
    send(12'h005, 12'h007, 1'b1, 1'b1, 1'b0);
    send(12'h000, 12'h000, 1'b0, 1'b0, 1'b1);

    repeat (2) @(posedge iClk);
    #1;
    rdy_mode = 2;
    send(12'hFFF, 12'h001, 1'b0, 1'b1, 1'b0);
    fork
      send(12'hFFF, 12'h000, 1'b0, 1'b0, 1'b0);
      begin
        repeat (5) @(posedge iClk);
        rdy_mode = 0;
      end
    join
    send(12'h000, 12'h000, 1'b1, 1'b0, 1'b1);

    send(12'h123, 12'h456, 1'b0, 1'b0, 1'b0);
    send(12'h111, 12'h222, 1'b0, 1'b1, 1'b0);
    send(12'h333, 12'h444, 1'b1, 1'b1, 1'b0);
    send(12'h555, 12'h111, 1'b0, 1'b0, 1'b1);

    send(12'h800, 12'h900, 1'b0, 1'b1, 1'b0);
    send(12'hABC, 12'h544, 1'b0, 1'b0, 1'b0);
    send(12'h7FF, 12'h800, 1'b0, 1'b0, 1'b0);
    send(12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0);
    send(12'h001, 12'h002, 1'b0, 1'b0, 1'b1);

    rdy_mode = 2;
    send(12'h0AA, 12'h055, 1'b0, 1'b1, 1'b0);
    #2;
    iRst_n = 1'b0;
    #1;
    check("rst_async_oValid", bus.oValid, 0);
    check("rst_async_oLast", bus.oLast, 0);
    check("rst_async_oSum", bus.oSum, 0);
    @(posedge iClk);
    #1;
    iRst_n   = 1'b1;
    rdy_mode = 0;
    send(12'h00F, 12'h001, 1'b0, 1'b0, 1'b1);
    send(12'h00F, 12'h001, 1'b1, 1'b1, 1'b1);

    rdy_mode = 1;
    for (int op = 0; op < 60; op++) begin
      case ($urandom_range(0, 9))
        0:       send(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        1:       rand_op($urandom_range(1, 3), 1'b0);
        2:       rand_op(MAXL, 1'b0);
        default: rand_op($urandom_range(1, MAXL), 1'b1);
      endcase
      gap();
      @(posedge iClk);
      #1;
    end

    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge iClk);
      n++;
    end
    repeat (3) @(posedge iClk);
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mp_limb_serial_addsub.md
Name: mp_limb_serial_addsub

Overview:
Limb-serial multi-precision adder/subtractor. It consumes wide operands as a stream of LIMB_WIDTH-bit limbs, least-significant limb first. It emits one sum limb per accepted beat and carries the limb carry across cycles in a register. This is the consuming end of the group carry logic: each limb's carry-out is formed from the limb's group generate/propagate and the registered carry-in. It sits between the operand stream source and the result sink in the multi-precision datapath.

Parameters:
LIMB_WIDTH, 12, bits per limb.
MAX_LIMBS, 16, maximum limbs per operation; the limb counter width is clog2(MAX_LIMBS).

Ports:
iClk  input  1  clock; all state updates on the rising edge.
iRst_n  input  1  asynchronous active-low reset.
iValid  input  1  input beat valid.
oReady  output  1  input beat accepted when iValid && oReady.
iA  input  LIMB_WIDTH  operand A limb.
iB  input  LIMB_WIDTH  operand B limb.
iSub  input  1  1 = A-B, 0 = A+B; sampled only on the first beat.
iFirst  input  1  marks the least-significant limb of an operation.
iLast  input  1  marks the most-significant limb of an operation.
oValid  output  1  output beat valid.
iReady  input  1  sink accepts output when oValid && iReady.
oSum  output  LIMB_WIDTH  result limb.
oLast  output  1  final limb of an operation.
oC  output  1  carry-out of the final limb; valid only with oLast.
oErr  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset values: oValid=0, oSum=0, oLast=0, oC=0, oErr=0. State=IDLE, carry register=0, limb count=0.
- oReady = !oValid || iReady. This is a single output register stage with full throughput. Latency is 1 cycle from accept to oValid.
- Per-limb operation on accept:
  - Bop = iSub_eff ? ~iB : iB.
  - Carry-in cin = iFirst ? iSub : carry_reg.
  - {cout, sum} = iA + Bop + cin, computed at LIMB_WIDTH+1 bits.
  - G = carry out of iA+Bop with cin=0. P = &(iA ^ Bop). cout = G | (P & cin).
  - cout is written into carry_reg. sum goes to oSum.
- iSub_eff = iSub on the first beat; otherwise the mode latched on the first beat. iSub on non-first beats is ignored.
- oC is the raw carry. For subtraction, oC=1 means no borrow (A>=B); oC=0 means borrow.
- FSM:
  - IDLE + accept with iFirst: if iLast also set, emit a single-limb result with oLast=1 and stay in IDLE. Otherwise go to RUN with count=1.
  - IDLE + accept with !iFirst: the beat is consumed and discarded, no output is produced, oErr pulses, and state stays IDLE.
  - RUN + accept with !iFirst: emit the limb and increment count. If iLast, emit with oLast=1 and return to IDLE.
  - RUN + accept with iFirst: the current operation is abandoned with no oLast emitted. oErr pulses and a new operation starts with this beat; iFirst/iLast are processed as in IDLE.
  - RUN, count==MAX_LIMBS-1 and the accepted beat lacks iLast: the beat is emitted with oLast forced to 1, oErr pulses, and state returns to IDLE.
- Output holds stable while oValid && !iReady. No input is accepted during that time, and carry_reg and count hold.
- Asynchronous reset mid-operation clears all state immediately. Any in-flight output beat is lost.

Optional Feature:
CLA_GP_OUT_EN:
- Defined: adds output ports oG and oP (1 bit each), registered alongside oSum. They carry the limb group generate/propagate, so an external lookahead unit can recompute carries.
- Undefined: these ports and registers do not exist. Core behaviour is identical either way.

Test Plan:
1. Reset, then single beat iFirst=iLast=1, iA=12'hFFF, iB=12'h001, iSub=0 -> next cycle oValid=1, oSum=12'h000, oC=1, oLast=1.
2. Three-limb add A=36'h000_FFF_FFF, B=36'h000_000_001 -> oSum sequence 12'h000, 12'h000, 12'h001. oLast on the third beat, oC=0.
3. Two-limb sub A=24'h000_005, B=24'h000_007, iSub=1 on the first beat only -> oSum 12'hFFE, 12'hFFF. oC=0 (borrow).
4. Backpressure: hold iReady=0 for 5 cycles during test 2 -> oReady=0, oSum stable, and the final sequence and carries are unchanged.
5. Framing errors:
   - Beat with iFirst=0 in IDLE -> no output, oErr=1 for one cycle.
   - iFirst arriving mid-RUN -> oErr pulse, and the new operation's result is correct.
6. With MAX_LIMBS=4, feed 4 beats without iLast -> the 4th output has oLast=1 and oErr pulses. Assert reset mid-stream -> oValid=0 immediately.
